// File: rtl/regfile.sv
// Integer register file with two bypassed read ports and a per-register
// pending-write scoreboard that drives operand busy flags for the stall logic.
module regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              wb_we_in,
  input  logic [ADDR_W-1:0] wb_addr_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic              issue_in,
  input  logic [ADDR_W-1:0] issue_addr_in,
  input  logic              cancel_in,
  input  logic [ADDR_W-1:0] cancel_addr_in,
  input  logic              re1_in,
  input  logic [ADDR_W-1:0] raddr1_in,
  output logic [DATA_W-1:0] rdata1_out,
  output logic              busy1_out,
  input  logic              re2_in,
  input  logic [ADDR_W-1:0] raddr2_in,
  output logic [DATA_W-1:0] rdata2_out,
  output logic              busy2_out,
  output logic              sb_err_out
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  // Two guard bits hold the worst-case sum (max+1) and the sign of an underflow.
  localparam int unsigned SW   = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] r_mem [NREG];
  logic [CNT_W-1:0]  r_cnt [NREG];
  logic              r_err;
  logic              r_armed;

  logic              w_wb_v;
  logic              w_iss_v;
  logic              w_can_v;
  logic              w_armed;
  logic [SW-1:0]     w_sum   [NREG];
  logic [CNT_W-1:0]  w_cnt_d [NREG];
  logic [NREG-1:0]   w_ovf;
  logic [NREG-1:0]   w_unf;
  logic              w_err_d;

  logic              w_rd1;
  logic              w_rd2;
  logic              w_ret1;
  logic              w_ret2;
  logic [CNT_W-1:0]  w_cnt_rd1;
  logic [CNT_W-1:0]  w_cnt_rd2;

  // x0 is excluded here, so its storage and counter never move from reset.
  assign w_wb_v  = wb_we_in  && (wb_addr_in     != '0);
  assign w_iss_v = issue_in  && (issue_addr_in  != '0);
  assign w_can_v = cancel_in && (cancel_addr_in != '0);

  // Underflows are silent until the first issue after reset, since stale
  // write-backs from before the reset are still draining.
  assign w_armed = r_armed || w_iss_v;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_sum[i] = SW'(r_cnt[i])
               + SW'(w_iss_v && (issue_addr_in  == ADDR_W'(i)))
               - SW'(w_wb_v  && (wb_addr_in     == ADDR_W'(i)))
               - SW'(w_can_v && (cancel_addr_in == ADDR_W'(i)));
      w_unf[i] = w_sum[i][SW-1];
      w_ovf[i] = !w_sum[i][SW-1] && (w_sum[i] > SW'(CNT_MAX));
      if (w_unf[i]) begin
        w_cnt_d[i] = '0;
      end else if (w_ovf[i]) begin
        w_cnt_d[i] = CNT_MAX;
      end else begin
        w_cnt_d[i] = w_sum[i][CNT_W-1:0];
      end
    end
    w_err_d = r_err || (|w_ovf) || (w_armed && (|w_unf));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
        r_cnt[i] <= '0;
      end
      r_err   <= 1'b0;
      r_armed <= 1'b0;
    end else if (rdy_in) begin
      if (w_wb_v) begin
        r_mem[wb_addr_in] <= wb_data_in;
      end
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
      r_err   <= w_err_d;
      r_armed <= w_armed;
    end
  end

  // Reads are forced quiet while reset is held so bypass cannot leak through.
  assign w_rd1 = re1_in && rst_in && (raddr1_in != '0);
  assign w_rd2 = re2_in && rst_in && (raddr2_in != '0);

  assign w_ret1 = wb_we_in && (wb_addr_in == raddr1_in);
  assign w_ret2 = wb_we_in && (wb_addr_in == raddr2_in);

  assign w_cnt_rd1 = r_cnt[raddr1_in] - CNT_W'(w_ret1);
  assign w_cnt_rd2 = r_cnt[raddr2_in] - CNT_W'(w_ret2);

  always_comb begin
    rdata1_out = '0;
    busy1_out  = 1'b0;
    if (w_rd1) begin
      rdata1_out = w_ret1 ? wb_data_in : r_mem[raddr1_in];
      busy1_out  = (w_cnt_rd1 != '0);
    end
  end

  always_comb begin
    rdata2_out = '0;
    busy2_out  = 1'b0;
    if (w_rd2) begin
      rdata2_out = w_ret2 ? wb_data_in : r_mem[raddr2_in];
      busy2_out  = (w_cnt_rd2 != '0);
    end
  end

  assign sb_err_out = r_err;

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Integer register file at the write-back end of the pipeline. Consumes the write-back triple from the MEM/WB stage register and serves two combinational read ports to ID.
- Same-cycle write-to-read bypass on both read ports.
- Per-register pending-write scoreboard: ID marks a destination at issue, EX cancels flushed instructions, write-back retires. The stall controller uses the resulting busy flags to hold dependent instructions.

Parameters:
- DATA_W, 32, register width (`RegBus)
- ADDR_W, 5, register index width (`RegAddrBus); 2**ADDR_W registers
- CNT_W, 2, pending-write counter width per register; saturates at 2**CNT_W-1

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low freezes all state
- wb_we_in  input  1  write-back enable (rd_wb)
- wb_addr_in  input  ADDR_W  write-back register index
- wb_data_in  input  DATA_W  write-back value
- issue_in  input  1  ID issued an instruction that writes issue_addr_in
- issue_addr_in  input  ADDR_W  destination of the issued instruction
- cancel_in  input  1  EX flushed an in-flight instruction that had marked cancel_addr_in
- cancel_addr_in  input  ADDR_W  destination of the flushed instruction
- re1_in  input  1  read port 1 enable
- raddr1_in  input  ADDR_W  read port 1 index
- rdata1_out  output  DATA_W  read port 1 data
- busy1_out  output  1  read port 1 operand not yet available
- re2_in, raddr2_in, rdata2_out, busy2_out: same as port 1
- sb_err_out  output  1  sticky scoreboard overflow/underflow flag

Behaviour:
- Reset (rst_in=0, asynchronous): all registers 0, all counters 0, sb_err_out=0. Read outputs are combinational, so reads return 0 and busy=0 during reset.
- Register x0: reads always return 0 with busy=0. Writes, issues and cancels to x0 are ignored.
- Write: on posedge with rdy_in=1, wb_we_in=1 and wb_addr_in!=0, store wb_data_in. Takes effect next cycle.
- Read port n, combinational, in priority order:
  - re_n=0 -> data 0, busy 0.
  - addr=0 -> data 0, busy 0.
  - wb_we_in=1 and wb_addr_in==addr -> data = wb_data_in (bypass).
  - otherwise -> stored value.
- busy_n = (cnt[addr] − retire_this_cycle(addr)) != 0, where retire_this_cycle(addr) is 1 when wb_we_in is set to that addr. A register whose last pending write is retiring this cycle reads not-busy with bypassed data.
- Counter update per register r!=0, on posedge with rdy_in=1:
  - delta = +issue(r) − wb(r) − cancel(r), where each term is 1 when the port is valid and addressed to r.
  - Any combination of simultaneous events on the same r is legal and is summed; e.g. issue+wb on the same r leaves the count unchanged.
  - Overflow (result > max): counter saturates at max, sb_err_out set.
  - Underflow (result < 0): counter held at 0, sb_err_out set.
  - sb_err_out clears only on reset.
- rdy_in=0: no write, no counter update. Reads and busy remain combinational on current state.
- Reset mid-operation clears the scoreboard. In-flight write-backs that arrive after reset are legal writes and underflow-clamp silently without setting sb_err_out, until the first issue after reset.

Test Plan:
- Reset, then write x5=0xDEADBEEF; next cycle read port 1 x5 -> 0xDEADBEEF, busy1=0. Write x0=0x1234; read x0 on both ports -> 0.
- Same-cycle bypass: wb x7=0xA5A5A5A5 while port 2 reads x7 (stored 0) -> rdata2_out=0xA5A5A5A5 in that same cycle.
- Scoreboard: issue x3 -> busy1(x3)=1 next cycle. Issue x3 again (cnt=2). wb x3 -> still busy. Second wb x3 in the same cycle as a read -> busy=0, data bypassed. Following cycle busy=0.
- Simultaneous issue+wb to x9 with cnt=1 -> cnt stays 1, busy stays 1. Cancel x9 -> busy=0, sb_err_out=0.
- Saturation: four issues to x4 with no retires -> cnt=3, sb_err_out=1. A wb to x12 with cnt=0 also sets sb_err_out. Flag stays set until rst_in pulses low asynchronously mid-cycle, at which point all outputs read 0 immediately.
- rdy_in=0 with wb_we_in=1 to x6=0x55 and issue x6 -> x6 unchanged, cnt unchanged after rdy_in returns high.
